// File: rtl/can_fd_crc_pkg.sv
// Shared constants, FSM encoding and gray helper for the CAN FD receive CRC checker.
package can_fd_crc_pkg;

    localparam int          CRC17_W    = 17;
    localparam int          CRC21_W    = 21;
    localparam logic [16:0] CRC17_POLY = 17'h1685B;
    localparam logic [16:0] CRC17_INIT = 17'h10000;
    localparam logic [20:0] CRC21_POLY = 21'h102899;
    localparam logic [20:0] CRC21_INIT = 21'h100000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DATA     = 2'd1,
        ST_STC      = 2'd2,
        ST_WAIT_CRC = 2'd3
    } crc_state_e;

    function automatic logic [2:0] gray3(input logic [2:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/can_fd_crc_lfsr.sv
// Serial CRC LFSR; init and step in the same cycle steps from the init value.
module can_fd_crc_lfsr #(
    parameter int                WIDTH = 17,
    parameter logic [WIDTH-1:0]  POLY  = '0,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             step,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc_o
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] stepped;

    always_comb begin
        base    = init ? INIT : crc_o;
        stepped = {base[WIDTH-2:0], 1'b0} ^ ((bit_in ^ base[WIDTH-1]) ? POLY : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_o <= '0;
        end else if (step) begin
            crc_o <= stepped;
        end else if (init) begin
            crc_o <= INIT;
        end
    end

endmodule

// File: rtl/can_fd_crc_check.sv
// CAN FD receive CRC checker: CRC-17/CRC-21 over SOF..stuff count, stuff-count
// check against the destuffer, and final compare against the received CRC field.
module can_fd_crc_check
    import can_fd_crc_pkg::*;
#(
    parameter int Tp = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_point,
    input  logic        sof,
    input  logic        rx_bit,
    input  logic        crc_in_en,
    input  logic        stc_en,
    input  logic [2:0]  dyn_stuff_cnt,
    input  logic        crc_sel_21,
    input  logic        crc_rx_done,
    input  logic [16:0] crc_17_rx,
    input  logic [20:0] crc_21_rx,
    output logic        check_valid,
    output logic        crc_error,
    output logic        stuff_cnt_error,
    output logic        busy
);

    // Tp only matters to simulation models; reject nonsense values at elaboration.
    if (Tp < 0) begin : g_tp_range
        $error("can_fd_crc_check: Tp must be non-negative");
    end

    crc_state_e  state_q, state_d;
    logic [1:0]  stc_idx_q, stc_idx_d;
    logic [2:0]  gray_q, gray_d;
    logic        lfsr_init, lfsr_step;
    logic        check_valid_d, crc_error_d, stuff_err_d;
    logic [16:0] crc_17;
    logic [20:0] crc_21;
    logic        bit_ev, sof_ev;
    logic [2:0]  gray_exp;
    logic        stc_bad;

    assign bit_ev   = sample_point;
    assign sof_ev   = sample_point & sof;
    assign gray_exp = gray3(dyn_stuff_cnt);
    // On the 4th STC bit, rx_bit is the received parity; stored gray bits are complete.
    assign stc_bad  = (gray_q != gray_exp) | (rx_bit != ^gray_exp);

    can_fd_crc_lfsr #(.WIDTH(CRC17_W), .POLY(CRC17_POLY), .INIT(CRC17_INIT)) u_crc17 (
        .clk    (clk),
        .rst    (rst),
        .init   (lfsr_init),
        .step   (lfsr_step),
        .bit_in (rx_bit),
        .crc_o  (crc_17)
    );

    can_fd_crc_lfsr #(.WIDTH(CRC21_W), .POLY(CRC21_POLY), .INIT(CRC21_INIT)) u_crc21 (
        .clk    (clk),
        .rst    (rst),
        .init   (lfsr_init),
        .step   (lfsr_step),
        .bit_in (rx_bit),
        .crc_o  (crc_21)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sof_ev) begin
            state_d = ST_DATA;
        end else begin
            case (state_q)
                ST_DATA:     if (bit_ev && stc_en) state_d = ST_STC;
                ST_STC:      if (bit_ev && stc_en && stc_idx_q == 2'd3) state_d = ST_WAIT_CRC;
                ST_WAIT_CRC: if (crc_rx_done) state_d = ST_IDLE;
                default:     state_d = state_q;
            endcase
        end
    end

    // check_valid is a one-cycle strobe; crc_error is meaningful with it and holds until the next sof.
    always_comb begin
        lfsr_init     = 1'b0;
        lfsr_step     = 1'b0;
        stc_idx_d     = stc_idx_q;
        gray_d        = gray_q;
        check_valid_d = 1'b0;
        crc_error_d   = crc_error;
        stuff_err_d   = stuff_cnt_error;
        if (sof_ev) begin
            lfsr_init   = 1'b1;
            lfsr_step   = crc_in_en;
            stc_idx_d   = 2'd0;
            gray_d      = 3'd0;
            crc_error_d = 1'b0;
            stuff_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (bit_ev && stc_en) begin
                        lfsr_step = 1'b1;
                        gray_d[2] = rx_bit;
                        stc_idx_d = 2'd1;
                    end else if (bit_ev && crc_in_en) begin
                        lfsr_step = 1'b1;
                    end
                end
                ST_STC: begin
                    if (bit_ev && stc_en) begin
                        lfsr_step = 1'b1;
                        case (stc_idx_q)
                            2'd1: begin
                                gray_d[1] = rx_bit;
                                stc_idx_d = 2'd2;
                            end
                            2'd2: begin
                                gray_d[0] = rx_bit;
                                stc_idx_d = 2'd3;
                            end
                            2'd3: begin
                                stuff_err_d = stc_bad;
                                stc_idx_d   = 2'd0;
                            end
                            default: stc_idx_d = stc_idx_q;
                        endcase
                    end
                end
                ST_WAIT_CRC: begin
                    if (crc_rx_done) begin
                        check_valid_d = 1'b1;
                        crc_error_d   = crc_sel_21 ? (crc_21 != crc_21_rx)
                                                   : (crc_17 != crc_17_rx);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stc_idx_q       <= 2'd0;
            gray_q          <= 3'd0;
            check_valid     <= 1'b0;
            crc_error       <= 1'b0;
            stuff_cnt_error <= 1'b0;
            busy            <= 1'b0;
        end else begin
            stc_idx_q       <= stc_idx_d;
            gray_q          <= gray_d;
            check_valid     <= check_valid_d;
            crc_error       <= crc_error_d;
            stuff_cnt_error <= stuff_err_d;
            busy            <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_can_fd_crc_check.sv
// Directed bench for can_fd_crc_check with a serial CRC reference model.
module tb_can_fd_crc_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_point = 1'b0;
    logic        sof = 1'b0;
    logic        rx_bit = 1'b0;
    logic        crc_in_en = 1'b0;
    logic        stc_en = 1'b0;
    logic [2:0]  dyn_stuff_cnt = 3'd0;
    logic        crc_sel_21 = 1'b0;
    logic        crc_rx_done = 1'b0;
    logic [16:0] crc_17_rx = '0;
    logic [20:0] crc_21_rx = '0;
    logic        check_valid, crc_error, stuff_cnt_error, busy;

    int checks = 0;
    int errors = 0;
    logic [16:0] m17;
    logic [20:0] m21;

    can_fd_crc_check #(.Tp(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_point    (sample_point),
        .sof             (sof),
        .rx_bit          (rx_bit),
        .crc_in_en       (crc_in_en),
        .stc_en          (stc_en),
        .dyn_stuff_cnt   (dyn_stuff_cnt),
        .crc_sel_21      (crc_sel_21),
        .crc_rx_done     (crc_rx_done),
        .crc_17_rx       (crc_17_rx),
        .crc_21_rx       (crc_21_rx),
        .check_valid     (check_valid),
        .crc_error       (crc_error),
        .stuff_cnt_error (stuff_cnt_error),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic b);
        logic fb17, fb21;
        fb17 = b ^ m17[16];
        fb21 = b ^ m21[20];
        m17 = {m17[15:0], 1'b0} ^ (fb17 ? 17'h1685B : 17'h0);
        m21 = {m21[19:0], 1'b0} ^ (fb21 ? 21'h102899 : 21'h0);
    endtask

    // Drives one bit event after 'gap' idle cycles; returns at the negedge after it is sampled.
    task automatic send_bit(input logic b, input logic cen, input logic sen, input logic s, input int gap);
        repeat (gap) @(negedge clk);
        sample_point = 1'b1;
        rx_bit       = b;
        crc_in_en    = cen;
        stc_en       = sen;
        sof          = s;
        if (s) begin
            m17 = 17'h10000;
            m21 = 21'h100000;
        end
        if (cen || sen) model_step(b);
        @(negedge clk);
        sample_point = 1'b0;
        sof          = 1'b0;
        crc_in_en    = 1'b0;
        stc_en       = 1'b0;
    endtask

    task automatic run_frame(input int nbytes, input logic [2:0] cnt, input logic [3:0] stc,
                             input int gap, input logic [7:0] seed);
        logic [7:0] by;
        dyn_stuff_cnt = cnt;
        send_bit(1'b0, 1'b1, 1'b0, 1'b1, gap);
        for (int i = 0; i < nbytes; i++) begin
            by = seed + 8'(i * 29);
            for (int j = 7; j >= 0; j--) send_bit(by[j], 1'b1, 1'b0, 1'b0, gap);
        end
        for (int k = 3; k >= 0; k--) send_bit(stc[k], 1'b0, 1'b1, 1'b0, gap);
    endtask

    task automatic finish_crc(input string tag, input logic sel, input logic [16:0] r17,
                              input logic [20:0] r21, input logic exp_err);
        crc_sel_21  = sel;
        crc_17_rx   = r17;
        crc_21_rx   = r21;
        crc_rx_done = 1'b1;
        @(negedge clk);
        crc_rx_done = 1'b0;
        check({tag, "_valid"}, 32'(check_valid), 32'd1);
        check({tag, "_crc_err"}, 32'(crc_error), 32'(exp_err));
        @(negedge clk);
        check({tag, "_valid_1cyc"}, 32'(check_valid), 32'd0);
        check({tag, "_hold"}, 32'(crc_error), 32'(exp_err));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(check_valid), 32'd0);
        check("rst_crc_err", 32'(crc_error), 32'd0);
        check("rst_stc_err", 32'(stuff_cnt_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // crc_rx_done while idle must be ignored
        crc_rx_done = 1'b1;
        @(negedge clk);
        crc_rx_done = 1'b0;
        check("idle_done_valid", 32'(check_valid), 32'd0);
        check("idle_done_busy", 32'(busy), 32'd0);

        // 8-byte frame, stuff count 5 -> gray 111, parity 1
        run_frame(8, 3'd5, 4'b1111, 0, 8'h3C);
        check("sc5_ok", 32'(stuff_cnt_error), 32'd0);
        check("sc5_busy", 32'(busy), 32'd1);
        finish_crc("f8_good", 1'b0, m17, 21'h0, 1'b0);

        run_frame(8, 3'd5, 4'b1111, 0, 8'h3C);
        finish_crc("f8_bit3", 1'b0, m17 ^ 17'h00008, 21'h0, 1'b1);

        // wrong parity
        run_frame(2, 3'd5, 4'b1110, 0, 8'hA5);
        check("sc5_par_err", 32'(stuff_cnt_error), 32'd1);
        finish_crc("f2_par", 1'b0, m17, 21'h0, 1'b0);
        check("sc5_par_hold", 32'(stuff_cnt_error), 32'd1);

        // SOF + stuff count 0 (0000): CRC-17 worked by hand = 0x06604
        run_frame(0, 3'd0, 4'b0000, 0, 8'h00);
        check("sc0_ok", 32'(stuff_cnt_error), 32'd0);
        finish_crc("hand17", 1'b0, 17'h06604, 21'h0, 1'b0);

        run_frame(3, 3'd3, 4'b0101, 0, 8'h11);
        check("sc3_ok", 32'(stuff_cnt_error), 32'd0);
        finish_crc("f3_good", 1'b0, m17, 21'h0, 1'b0);

        // 64-byte frame, CRC-21 selected, garbage on the CRC-17 input
        run_frame(64, 3'd6, 4'b1010, 0, 8'h5A);
        check("sc6_ok", 32'(stuff_cnt_error), 32'd0);
        finish_crc("f64_good", 1'b1, ~m17, m21, 1'b0);
        run_frame(64, 3'd6, 4'b1010, 0, 8'h5A);
        finish_crc("f64_bad", 1'b1, m17, m21 ^ 21'h100000, 1'b1);

        // bit events every 4th cycle must give the same CRCs as back-to-back bits
        run_frame(8, 3'd5, 4'b1111, 3, 8'h3C);
        finish_crc("gap21", 1'b1, 17'h0, m21, 1'b0);
        run_frame(8, 3'd7, 4'b1001, 3, 8'h77);
        check("sc7_ok", 32'(stuff_cnt_error), 32'd0);
        finish_crc("gap17", 1'b0, m17, 21'h0, 1'b0);

        // reset while in STC aborts without a check
        dyn_stuff_cnt = 3'd5;
        send_bit(1'b0, 1'b1, 1'b0, 1'b1, 0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 1'b1, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(check_valid), 32'd0);
        crc_rx_done = 1'b1;
        @(negedge clk);
        crc_rx_done = 1'b0;
        check("abort_done_valid", 32'(check_valid), 32'd0);

        // new sof while waiting for the CRC clears flags and reinitialises the LFSRs
        run_frame(1, 3'd2, 4'b1111, 0, 8'h42);
        check("sc2_err", 32'(stuff_cnt_error), 32'd1);
        dyn_stuff_cnt = 3'd0;
        send_bit(1'b0, 1'b1, 1'b0, 1'b1, 0);
        check("resof_clear", 32'(stuff_cnt_error), 32'd0);
        check("resof_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) send_bit(1'b0, 1'b0, 1'b1, 1'b0, 0);
        finish_crc("resof_crc", 1'b0, 17'h06604, 21'h0, 1'b0);

        // sof and crc_rx_done together: sof wins
        run_frame(1, 3'd2, 4'b0110, 0, 8'h99);
        check("sc2_ok", 32'(stuff_cnt_error), 32'd0);
        dyn_stuff_cnt = 3'd0;
        crc_rx_done   = 1'b1;
        send_bit(1'b0, 1'b1, 1'b0, 1'b1, 0);
        crc_rx_done   = 1'b0;
        check("sof_wins_valid", 32'(check_valid), 32'd0);
        check("sof_wins_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) send_bit(1'b0, 1'b0, 1'b1, 1'b0, 0);
        finish_crc("sof_wins_crc", 1'b1, 17'h0, m21, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_fd_crc_check.md
# can_fd_crc_check

CAN FD receive CRC checker. Runs the CRC-17 and CRC-21 polynomials in parallel over the incoming bit stream from SOF to the end of the stuff-count field. It checks the received gray-coded stuff count against the destuffer's dynamic stuff-bit count. When the CRC field has been fully collected by the CRC destuff stage, it compares the selected calculated CRC with the received one. It sits between the bit-stream processor/destuffer and the error-management logic, downstream of the CRC destuff stage.

## Interface
- Parameter `Tp`, default 1: register update delay used in simulation.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_point` in 1: strobe marking the cycle in which `rx_bit` is the sampled bus bit.
- `sof` in 1: start-of-frame strobe, valid only together with `sample_point`.
- `rx_bit` in 1: sampled bus bit.
- `crc_in_en` in 1: the bit is CRC input. Asserted from SOF to the end of the data field, including dynamic stuff bits.
- `stc_en` in 1: the bit belongs to the stuff-count field (3 gray bits, then parity). Never asserted on fixed stuff bits.
- `dyn_stuff_cnt` in 3: count of dynamic stuff bits modulo 8 from the destuffer. Stable while `stc_en` bits arrive.
- `crc_sel_21` in 1: 1 selects CRC-21 (payload above 16 bytes); 0 selects CRC-17. Sampled on `crc_rx_done`.
- `crc_rx_done` in 1: one-cycle pulse. Means `crc_17_rx`/`crc_21_rx` hold the complete received CRC.
- `crc_17_rx` in 17, `crc_21_rx` in 21: received CRC from the destuff stage.
- `check_valid` out 1: one-cycle pulse when the CRC compare result is valid.
- `crc_error` out 1: CRC mismatch. Held until the next `sof` or `rst`.
- `stuff_cnt_error` out 1: stuff-count or parity mismatch. Held until the next `sof` or `rst`.
- `busy` out 1: 1 in every state except IDLE.

## Operation
- **FSM states:** IDLE, DATA, STC, WAIT_CRC.
- **Bit event:** a cycle with `sample_point`=1.
- **On `sof` bit event (any state):**
  - Load CRC-17 with 0x10000 and CRC-21 with 0x100000.
  - Clear both error flags and the STC bit index.
  - Go to DATA.
  - If `crc_in_en`=1 in the same cycle, step both LFSRs from the init value with `rx_bit`. SOF is therefore included.
- **LFSR step:** `fb = rx_bit ^ crc[MSB]`; `crc = {crc[MSB-1:0],1'b0} ^ (fb ? POLY : 0)`.
  - CRC-17 POLY 0x1685B.
  - CRC-21 POLY 0x102899.
- **DATA:**
  - A bit event with `crc_in_en` steps both LFSRs.
  - The first bit event with `stc_en` steps both LFSRs, stores that bit as gray[2], and goes to STC with index 1.
- **STC:**
  - Each `stc_en` bit event steps both LFSRs and stores the bit (gray[1], gray[0], then parity).
  - On the 4th bit, compare the stored bits against `gray(dyn_stuff_cnt)` and `parity = ^gray`.
  - Set `stuff_cnt_error` on any difference, then go to WAIT_CRC.
- **Gray encoding:** 0→000, 1→001, 2→011, 3→010, 4→110, 5→111, 6→101, 7→100.
- **WAIT_CRC:**
  - LFSRs frozen.
  - On `crc_rx_done`: `crc_error` = (`crc_sel_21` ? `crc_21` != `crc_21_rx` : `crc_17` != `crc_17_rx`). Pulse `check_valid`, go to IDLE.
- **Ignored inputs:**
  - `crc_in_en` outside DATA (and outside a `sof` cycle).
  - `stc_en` in IDLE and WAIT_CRC.
  - `crc_rx_done` outside WAIT_CRC: no pulse, no flag change.
- `sof` and `crc_rx_done` in the same cycle: `sof` wins, no `check_valid`.
- Widths: all compares are full width; no truncation.

## Timing
- **Reset values:** state IDLE, LFSRs 0, `check_valid` 0, `crc_error` 0, `stuff_cnt_error` 0, `busy` 0.
- Reset mid-frame aborts to IDLE in the next cycle. No `check_valid` is issued.
- All outputs are registered.
- **Latencies:**
  - LFSR update is visible 1 cycle after the bit event.
  - `stuff_cnt_error` is valid 1 cycle after the 4th STC bit event.
  - `check_valid` and the `crc_error` update occur 1 cycle after `crc_rx_done`.
- `check_valid` is exactly 1 cycle wide. The flags stay stable after it.
- Back-to-back frames: a `sof` the cycle after `check_valid` is accepted.

## Structure
- **Package `can_fd_crc_pkg`:**
  - POLY and INIT constants for CRC-17 and CRC-21.
  - FSM state enum.
  - `gray3` function.
- **Sub-module `can_fd_crc_lfsr`:** parameterised by WIDTH, POLY and INIT; ports `clk`, `rst`, `init`, `step`, `bit_in`, `crc_o`.
  - One instance for CRC-17, one for CRC-21.
  - The checker holds the FSM, STC capture and compare.

## Test plan
- **Stuff count 5, correct:** `dyn_stuff_cnt`=5, STC bits 1,1,1,1 → `stuff_cnt_error`=0. Gray bits 1,1,1 with parity 0 → `stuff_cnt_error`=1.
- **Stuff count 0, correct:** `dyn_stuff_cnt`=0, bits 0,0,0,0 → no error. `dyn_stuff_cnt`=3 with bits 0,1,0,1 → no error.
- **Good 8-byte FD frame:** golden-model CRC-17 driven on `crc_17_rx`, `crc_sel_21`=0 → `check_valid` 1 cycle after `crc_rx_done`, `crc_error`=0. Same frame with `crc_17_rx` bit 3 flipped → `crc_error`=1.
- **Good 64-byte frame:** `crc_sel_21`=1, golden CRC-21 → `crc_error`=0. Garbage on `crc_17_rx` is ignored.
- **Abort and ignore:**
  - `rst` asserted in STC → next cycle `busy`=0, no `check_valid`.
  - `crc_rx_done` in IDLE → no pulse.
  - New `sof` in WAIT_CRC → both flags cleared, LFSRs reinitialised.
- **Gaps between bit events:** bit events every 4th cycle with idle cycles between → LFSR values identical to a back-to-back bit stream.
